// File: rtl/pulse_capture_ctrl.sv
// Threshold-armed window sequencer feeding the pulse CIR averaging core.
// Optional post-window sample holdoff is enabled by defining PULSE_HOLDOFF_EN.
module pulse_capture_ctrl #(
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [31:0]       threshold,
    input  logic [15:0]       seq_len,
    input  logic [CNT_W-1:0]  avg_size,
`ifdef PULSE_HOLDOFF_EN
    input  logic [15:0]       holdoff,
`endif
    input  logic [31:0]       s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    input  logic              res_tvalid,
    input  logic              res_tready,
    input  logic              res_tlast,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  pulse_cnt,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    state_t            r_state;
    logic [15:0]       r_seq_len;
    logic [CNT_W-1:0]  r_avg;
    logic [15:0]       r_samp_cnt;
    logic [CNT_W-1:0]  r_pulse_cnt;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [31:0]       r_m_tdata;
    logic              r_m_tvalid;
    logic              r_m_tlast;

    logic [16:0]       w_i;
    logic [16:0]       w_q;
    logic [16:0]       w_abs_i;
    logic [16:0]       w_abs_q;
    logic [16:0]       w_mag;
    logic              w_above;
    logic              w_out_ok;
    logic              w_acc;
    logic              w_fwd;
    logic              w_last;
    logic              w_win_end;
    logic              w_res_done;
    logic              w_start_ok;
    logic              w_hold_active;
    logic [CNT_W-1:0]  w_pulse_nxt;
    logic              w_unused;

`ifdef PULSE_HOLDOFF_EN
    logic [15:0]       r_hold_cnt;
    assign w_hold_active = (r_hold_cnt != '0);
`else
    assign w_hold_active = 1'b0;
`endif

    assign w_unused = s_tlast;

    // Sign-extend to 17 bits so |-32768| = 32768 without wrapping.
    assign w_i     = {s_tdata[31], s_tdata[31:16]};
    assign w_q     = {s_tdata[15], s_tdata[15:0]};
    assign w_abs_i = w_i[16] ? (~w_i + 17'd1) : w_i;
    assign w_abs_q = w_q[16] ? (~w_q + 17'd1) : w_q;
    assign w_mag   = w_abs_i + w_abs_q;
    assign w_above = ({15'd0, w_mag} > threshold);

    assign w_out_ok = !r_m_tvalid || m_tready;

    always_comb begin
        s_tready = 1'b0;
        case (r_state)
            ST_IDLE:    s_tready = 1'b0;
            ST_ARM:     s_tready = (w_hold_active || !w_above) ? 1'b1 : w_out_ok;
            ST_CAPTURE: s_tready = w_out_ok;
            ST_WAIT:    s_tready = 1'b1;
            default:    s_tready = 1'b0;
        endcase
    end

    assign w_acc       = s_tvalid && s_tready;
    assign w_fwd       = w_acc && (((r_state == ST_ARM) && !w_hold_active && w_above) ||
                                   (r_state == ST_CAPTURE));
    assign w_last      = (r_state == ST_ARM) ? (r_seq_len == 16'd1)
                                             : (r_samp_cnt == (r_seq_len - 16'd1));
    assign w_win_end   = w_fwd && w_last;
    assign w_res_done  = res_tvalid && res_tready && res_tlast;
    assign w_start_ok  = enable && (seq_len != '0) && (avg_size != '0);
    assign w_pulse_nxt = r_pulse_cnt + CNT_W'(1);

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            r_state     <= ST_IDLE;
            r_seq_len   <= '0;
            r_avg       <= '0;
            r_samp_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_drop_cnt  <= '0;
            r_m_tdata   <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
`ifdef PULSE_HOLDOFF_EN
            r_hold_cnt  <= '0;
`endif
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_seq_len   <= '0;
            r_avg       <= '0;
            r_samp_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_drop_cnt  <= '0;
            r_m_tdata   <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
`ifdef PULSE_HOLDOFF_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            if (w_out_ok) begin
                r_m_tvalid <= w_fwd;
                if (w_fwd) begin
                    r_m_tdata <= s_tdata;
                    r_m_tlast <= w_last;
                end
            end

            if (w_acc && !w_fwd && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end

            // Window end is shared by ARM (seq_len = 1) and CAPTURE.
            if (w_win_end) begin
                r_samp_cnt <= '0;
                if (w_pulse_nxt == r_avg) begin
                    r_state     <= ST_WAIT;
                    r_pulse_cnt <= w_pulse_nxt;
                end else if (!enable) begin
                    r_state     <= ST_IDLE;
                    r_pulse_cnt <= '0;
                end else begin
                    r_state     <= ST_ARM;
                    r_pulse_cnt <= w_pulse_nxt;
`ifdef PULSE_HOLDOFF_EN
                    r_hold_cnt  <= holdoff;
`endif
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_ok) begin
                            r_state    <= ST_ARM;
                            r_seq_len  <= seq_len;
                            r_avg      <= avg_size;
                            r_samp_cnt <= '0;
                        end
                    end
                    ST_ARM: begin
                        if (w_fwd) begin
                            r_state    <= ST_CAPTURE;
                            r_samp_cnt <= 16'd1;
                        end else begin
`ifdef PULSE_HOLDOFF_EN
                            if (w_acc && w_hold_active) begin
                                r_hold_cnt <= r_hold_cnt - 16'd1;
                            end
`endif
                            if (!enable) begin
                                r_state     <= ST_IDLE;
                                r_pulse_cnt <= '0;
`ifdef PULSE_HOLDOFF_EN
                                r_hold_cnt  <= '0;
`endif
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (w_fwd) begin
                            r_samp_cnt <= r_samp_cnt + 16'd1;
                        end
                    end
                    ST_WAIT: begin
                        if (w_res_done) begin
                            r_pulse_cnt <= '0;
                            r_state     <= enable ? ST_ARM : ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign state     = r_state;
    assign pulse_cnt = r_pulse_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/pulse_capture_ctrl.md
Name: pulse_capture_ctrl

Overview:
- Sequencer in front of the pulse CIR averaging core, between the axi_wrapper data master and the core's i_data stream.
- Arms on a threshold crossing (|I|+|Q| > threshold).
- Forwards exactly seq_len samples per pulse window, with tlast on the final sample.
- Repeats for avg_size windows, then blocks further capture until the core's averaged output packet has been consumed.

Parameters:
- CNT_W, 32, width of pulse counter and avg_size compare.
- DROP_W, 16, width of dropped-sample counter (saturating).

Ports:
- ce_clk  in  1  block clock.
- ce_rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous soft reset (block_reset setting reg); same effect as ce_rst.
- enable  in  1  1 = run; 0 = return to IDLE at the next window boundary.
- threshold  in  32  unsigned magnitude threshold.
- seq_len  in  16  samples per window.
- avg_size  in  CNT_W  windows per average.
- s_tdata  in  32  sample, I = [31:16], Q = [15:0], signed.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- s_tlast  in  1  ignored.
- m_tdata  out  32  sample to averaging core.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  last sample of window.
- res_tvalid  in  1  core o_data valid (monitor only).
- res_tready  in  1  core o_data ready (monitor only).
- res_tlast  in  1  core o_data last (monitor only).
- state  out  2  0 IDLE, 1 ARM, 2 CAPTURE, 3 WAIT_RESULT.
- pulse_cnt  out  CNT_W  windows completed in current average.
- drop_cnt  out  DROP_W  samples discarded outside windows, saturating.

Behaviour:
- Reset (ce_rst async, or clear sync) values: state IDLE, m_tvalid 0, m_tlast 0, m_tdata 0, pulse_cnt 0, drop_cnt 0, sample counter 0.
- Magnitude: mag = |I| + |Q|, 17-bit unsigned. |-32768| = 32768, no wrap. Zero-extend mag to 32 bits; above = (mag > threshold).
- Output register: one stage, latency 1 cycle from s accept to m_tvalid.
  - Register loads when (!m_tvalid || m_tready) and a forwarded sample is accepted.
  - m_tdata and m_tlast are stable while m_tvalid && !m_tready.
- IDLE:
  - s_tready = 0.
  - Moves to ARM when enable = 1, seq_len != 0 and avg_size != 0. On that transition, latch seq_len and avg_size into shadow regs.
  - Shadow regs are unchanged until the next IDLE->ARM transition.
- ARM:
  - Non-above sample: s_tready = 1, sample dropped, drop_cnt += 1.
  - Above sample: s_tready = (!m_tvalid || m_tready). Sample is forwarded as window sample 0; go to CAPTURE.
  - If shadow seq_len = 1, that sample carries m_tlast and the window-end rule below applies at once.
  - enable = 0 in ARM: go to IDLE.
- CAPTURE:
  - s_tready = (!m_tvalid || m_tready). Every accepted sample is forwarded regardless of magnitude.
  - Sample counter increments per accepted sample. The sample with counter = seq_len-1 carries m_tlast = 1.
  - Window end:
    - pulse_cnt += 1.
    - If the new pulse_cnt == avg_size: go to WAIT_RESULT.
    - Else if enable = 0: go to IDLE, pulse_cnt = 0.
    - Else: go to ARM.
- WAIT_RESULT:
  - s_tready = 1; samples dropped and counted.
  - Exit on the cycle with res_tvalid && res_tready && res_tlast: pulse_cnt = 0; go to ARM if enable else IDLE.
  - A result beat in any other state is ignored.
- drop_cnt saturates at all-ones and is never cleared except by reset/clear.
- Simultaneous window end and result handshake in CAPTURE: result ignored.
- clear asserted mid-window: output register cleared immediately. The core sees a truncated packet; it is reset by the same clear at top level.
- Config inputs change mid-operation: no effect until the next IDLE->ARM transition. threshold is used live, unlatched.

Optional Feature:
- Macro: PULSE_HOLDOFF_EN.
- With the macro defined:
  - Add input holdoff [15:0] and a HOLDOFF phase, reported as state ARM.
  - After each window end that returns toward ARM, the next holdoff accepted samples are dropped (s_tready = 1, drop_cnt increments) before threshold detection resumes.
  - holdoff = 0 behaves exactly as without the macro.
- Without the macro: no holdoff port; ARM follows the window end directly.

Test Plan:
- Basic capture: threshold = 100, seq_len = 4, avg_size = 2, enable = 1. Stimulus: I/Q = (10,10) x3, (80,30), then 3 more samples, then (0,0) x2, (0,-120), then 3 more samples.
  - Response: two 4-sample packets, each starting at the (80,30) / (0,-120) sample, m_tlast on the 4th sample; drop_cnt = 5.
  - State is WAIT_RESULT after the second window.
- Result gating: in WAIT_RESULT, drive 10 above-threshold samples, then a res beat with tlast.
  - Response: no m_tvalid; drop_cnt += 10; state -> ARM the cycle after the handshake; pulse_cnt = 0.
- Backpressure: m_tready toggling 1010 during CAPTURE, seq_len = 8.
  - Response: all 8 samples delivered in order, m_tdata stable while stalled, single tlast.
- Edge magnitude: threshold = 65535. Sample (-32768,-32768) (mag 65536) arms; (32767,32767) (mag 65534) does not. seq_len = 1: single-beat packet with m_tlast = 1.
- Reset mid-window: ce_rst pulsed after 2 of 4 samples. Response: m_tvalid = 0 asynchronously, state IDLE, pulse_cnt = 0. Config seq_len = 0: block stays IDLE, s_tready = 0.
- PULSE_HOLDOFF_EN build: holdoff = 3, seq_len = 2, avg_size = 3. Response: 3 samples dropped after each of the first two windows, even if above threshold.
